// File: rtl/draw_player_if.sv
// VGA stream bundle shared by the draw stages: counters, syncs, blanks, colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// Player sprite overlay: 2-stage pipeline that latches the sprite position once
// per frame, addresses the sprite ROM in stage 1 and keys the ROM colour over
// the background in stage 2. A two-frame walk animation selects the ROM half.
module draw_player #(
  parameter int unsigned PLAYER_W    = 32,
  parameter int unsigned PLAYER_H    = 48,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter int unsigned ANIM_DIV    = 8
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [11:0] xpos_player,
  input  logic [11:0] ypos_player,
  input  logic        moving,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_pixel
);

  localparam logic [11:0] X_MAX    = 12'(800 - PLAYER_W);
  localparam logic [11:0] Y_MAX    = 12'(600 - PLAYER_H);
  localparam logic [3:0]  CNT_LAST = 4'(ANIM_DIV - 1);

  typedef enum logic {IDLE, COUNT} anim_state_e;

  logic        vblnk_prev_q;
  logic        vblnk_rise;
  logic [11:0] x_l_q, y_l_q;
  logic        pos_vld_q;
  anim_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        frame_q, frame_d;

  logic [12:0] h13, v13, x_hi, y_hi;
  logic        in_sprite;
  logic [5:0]  row;
  logic [4:0]  col;

  logic [10:0] s1_h_q, s1_v_q, out_h_q, out_v_q;
  logic [3:0]  s1_ctl_q, out_ctl_q;
  logic [11:0] s1_rgb_q, out_rgb_q, rom_addr_q;
  logic        s1_in_q;

  assign vblnk_rise = vga_in.vblnk & ~vblnk_prev_q;

  // Edge detector for the start of vertical blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vblnk_prev_q <= 1'b0;
    else      vblnk_prev_q <= vga_in.vblnk;
  end

  // Position latch: sampled (and clamped) only at vblank start so a frame never tears.
  // pos_vld_q keeps the sprite hidden until the first real latch after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_l_q     <= '0;
      y_l_q     <= '0;
      pos_vld_q <= 1'b0;
    end else if (vblnk_rise) begin
      x_l_q     <= (xpos_player > X_MAX) ? X_MAX : xpos_player;
      y_l_q     <= (ypos_player > Y_MAX) ? Y_MAX : ypos_player;
      pos_vld_q <= 1'b1;
    end
  end

  // Animation state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Animation next state: all decisions are taken only at vblank start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (vblnk_rise) begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          frame_d = 1'b0;
          if (moving) state_d = COUNT;
        end
        COUNT: begin
          if (!moving) begin
            state_d = IDLE;
            cnt_d   = '0;
            frame_d = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            frame_d = ~frame_q;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sprite hit test in 13 bits so the right/bottom bounds cannot wrap.
  always_comb begin
    h13       = {2'b00, vga_in.hcount};
    v13       = {2'b00, vga_in.vcount};
    x_hi      = {1'b0, x_l_q} + 13'(PLAYER_W);
    y_hi      = {1'b0, y_l_q} + 13'(PLAYER_H);
    in_sprite = pos_vld_q && !vga_in.hblnk && !vga_in.vblnk &&
                (h13 >= {1'b0, x_l_q}) && (h13 < x_hi) &&
                (v13 >= {1'b0, y_l_q}) && (v13 < y_hi);
    col       = 5'(h13 - {1'b0, x_l_q});
    row       = 6'(v13 - {1'b0, y_l_q});
  end

  // Stage 1: delay the stream and register the ROM address while inside the sprite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      s1_ctl_q   <= '0;
      s1_rgb_q   <= '0;
      s1_in_q    <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      s1_h_q   <= vga_in.hcount;
      s1_v_q   <= vga_in.vcount;
      s1_ctl_q <= {vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk};
      s1_rgb_q <= vga_in.rgb;
      s1_in_q  <= in_sprite;
      if (in_sprite) rom_addr_q <= {frame_q, row, col};
    end
  end

  // Stage 2: key the ROM colour over the delayed background.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_h_q   <= '0;
      out_v_q   <= '0;
      out_ctl_q <= '0;
      out_rgb_q <= '0;
    end else begin
      out_h_q   <= s1_h_q;
      out_v_q   <= s1_v_q;
      out_ctl_q <= s1_ctl_q;
      out_rgb_q <= (s1_in_q && rom_pixel != TRANSPARENT) ? rom_pixel : s1_rgb_q;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign vga_out.hcount = out_h_q;
  assign vga_out.vcount = out_v_q;
  assign vga_out.hsync  = out_ctl_q[3];
  assign vga_out.vsync  = out_ctl_q[2];
  assign vga_out.hblnk  = out_ctl_q[1];
  assign vga_out.vblnk  = out_ctl_q[0];
  assign vga_out.rgb    = out_rgb_q;

endmodule

// File: tb/tb_draw_player.sv
// Directed bench for draw_player: reset, pass-through, sprite window, keying,
// clamp/latch, walk animation, asynchronous reset and stream timing.
module tb_draw_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] xpos = '0, ypos = '0;
  logic        moving = 1'b0;
  logic [11:0] rom_addr, rom_pixel;
  logic        key_col0 = 1'b0;
  int unsigned n_checks = 0, n_fail = 0;

  vga_if vin();
  vga_if vout();

  draw_player #(.PLAYER_W(32), .PLAYER_H(48), .TRANSPARENT(12'hF0F), .ANIM_DIV(8)) dut (
    .clk(clk), .rst(rst_n), .vga_in(vin), .vga_out(vout),
    .xpos_player(xpos), .ypos_player(ypos), .moving(moving),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel)
  );

  always #5 clk = ~clk;

  // Sprite ROM: solid green, optionally with a see-through first column.
  assign rom_pixel = (key_col0 && rom_addr[4:0] == 5'd0) ? 12'hF0F : 12'h0F0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic [10:0] h, input logic [10:0] v, input logic hs,
                        input logic vs, input logic hb, input logic vb, input logic [11:0] rgb);
    vin.hcount = h; vin.vcount = v; vin.hsync = hs; vin.vsync = vs;
    vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
  endtask

  task automatic neutral();
    set_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
  endtask

  // One-cycle vblank pulse: latches position and steps the animation.
  task automatic new_frame();
    set_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    @(negedge clk);
    neutral();
    @(negedge clk);
  endtask

  // Present one visible pixel and check the colour that emerges two cycles later.
  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] rgb_in, input logic [11:0] exp_rgb);
    set_in(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb_in);
    @(negedge clk);
    neutral();
    @(negedge clk);
    check_eq(tag, {20'd0, vout.rgb}, {20'd0, exp_rgb});
  endtask

  function automatic logic [31:0] pack_vin();
    return {6'd0, vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
  endfunction

  function automatic logic [31:0] pack_vout();
    return {6'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
  endfunction

  initial begin
    logic [31:0] hist[$];

    // Reset held with live input: everything must stay zero.
    set_in(11'd55, 11'd66, 1'b1, 1'b1, 1'b0, 1'b1, 12'hABC);
    xpos = 12'd100; ypos = 12'd200;
    repeat (3) @(negedge clk);
    check_eq("rst_timing", pack_vout(), 32'd0);
    check_eq("rst_rgb", {20'd0, vout.rgb}, 32'd0);
    check_eq("rst_addr", {20'd0, rom_addr}, 32'd0);
    neutral();
    rst_n = 1'b1;
    @(negedge clk);

    // Before the first vblank the sprite is hidden; colour passes through.
    probe("pre_vblank_pass", 11'd10, 11'd10, 12'hABC, 12'hABC);
    check_eq("pre_vblank_h", {21'd0, vout.hcount}, 32'd10);
    probe("pre_vblank_hidden", 11'd100, 11'd200, 12'h000, 12'h000);

    // Sprite window at (100,200), 32x48.
    new_frame();
    probe("spr_tl", 11'd100, 11'd200, 12'h000, 12'h0F0);
    probe("spr_br", 11'd131, 11'd247, 12'h000, 12'h0F0);
    check_eq("spr_br_addr", {20'd0, rom_addr}, 32'h5FF);
    check_eq("spr_br_h", {21'd0, vout.hcount}, 32'd131);
    check_eq("spr_br_v", {21'd0, vout.vcount}, 32'd247);
    probe("spr_left", 11'd99, 11'd200, 12'h000, 12'h000);
    probe("spr_right", 11'd132, 11'd200, 12'h000, 12'h000);
    probe("spr_above", 11'd100, 11'd199, 12'h000, 12'h000);
    probe("spr_below", 11'd100, 11'd248, 12'h000, 12'h000);
    set_in(11'd115, 11'd220, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    @(negedge clk); neutral(); @(negedge clk);
    check_eq("spr_hblnk", {20'd0, vout.rgb}, 32'h000);

    // Transparent first column shows the background.
    key_col0 = 1'b1;
    probe("key_col0", 11'd100, 11'd210, 12'h123, 12'h123);
    probe("key_col1", 11'd101, 11'd210, 12'h123, 12'h0F0);
    key_col0 = 1'b0;

    // Clamp to the right edge, then mid-frame move has no effect until vblank.
    xpos = 12'd790;
    new_frame();
    probe("clamp_l", 11'd768, 11'd200, 12'h000, 12'h0F0);
    probe("clamp_l_out", 11'd767, 11'd200, 12'h000, 12'h000);
    probe("clamp_r", 11'd799, 11'd247, 12'h000, 12'h0F0);
    xpos = 12'd300;
    probe("latch_hold_old", 11'd768, 11'd200, 12'h000, 12'h0F0);
    probe("latch_hold_new", 11'd300, 11'd200, 12'h000, 12'h000);
    new_frame();
    probe("latch_moved_new", 11'd300, 11'd200, 12'h000, 12'h0F0);
    probe("latch_moved_old", 11'd768, 11'd200, 12'h000, 12'h000);
    ypos = 12'd700;
    new_frame();
    probe("clamp_y_bot", 11'd300, 11'd599, 12'h000, 12'h0F0);
    probe("clamp_y_above", 11'd300, 11'd551, 12'h000, 12'h000);

    // Walk animation: ROM half toggles every 8 frames while moving.
    ypos = 12'd100;
    moving = 1'b1;
    for (int unsigned f = 1; f <= 25; f++) begin
      new_frame();
      probe("anim_pix", 11'd300, 11'd100, 12'h000, 12'h0F0);
      check_eq($sformatf("anim_f%0d", f), {20'd0, rom_addr}, {20'd0, 1'(((f - 1) / 8) % 2), 11'd0});
    end
    moving = 1'b0;
    probe("anim_hold", 11'd300, 11'd100, 12'h000, 12'h0F0);
    check_eq("anim_hold_addr", {20'd0, rom_addr}, 32'h800);
    new_frame();
    probe("anim_stop", 11'd300, 11'd100, 12'h000, 12'h0F0);
    check_eq("anim_stop_addr", {20'd0, rom_addr}, 32'h000);

    // Asynchronous reset in the middle of a line.
    set_in(11'd400, 11'd300, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456);
    @(negedge clk);
    set_in(11'd401, 11'd300, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456);
    @(negedge clk);
    check_eq("prerst_h", {21'd0, vout.hcount}, 32'd400);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_timing", pack_vout(), 32'd0);
    check_eq("async_rst_rgb", {20'd0, vout.rgb}, 32'd0);
    check_eq("async_rst_addr", {20'd0, rom_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stream: timing fields reappear exactly two cycles later.
    for (int unsigned i = 0; i < 40; i++) begin
      if (i >= 2) check_eq($sformatf("timing_%0d", i), pack_vout(), hist[i - 2]);
      set_in(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 12'($urandom));
      hist.push_back(pack_vin());
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
